fir_feeder: RTL

- Source-side driver for the FIR filter core. It is the transmitter for the filter's `data_ready`/`load_coeff`/`modwait` handshake.
- Buffers incoming samples in a small FIFO and holds a 4-entry coefficient bank.
- Sequences coefficient loads and sample pushes into the filter, waiting on `modwait` for each transfer.
- Captures `fir_out` and `err` into a result register when each sample completes. Sits between the system bus front end and the filter top level.

---
 rtl/fir_feeder.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_feeder.sv
// Source-side driver for the FIR filter core: sample FIFO, 4-entry coefficient bank and
// strobe/modwait sequencer. Define FIR_FEEDER_STATS_EN to add sample_count/drop_count.
module fir_feeder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int NUM_COEFF   = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        push,
    input  logic [15:0] push_data,
    output logic        fifo_full,
    input  logic        coeff_wr,
    input  logic [1:0]  coeff_idx,
    input  logic [15:0] coeff_wdata,
    input  logic        coeff_start,
    output logic [15:0] sample_data,
    output logic [15:0] fir_coefficient,
    output logic        data_ready,
    output logic        load_coeff,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        fir_err,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic        result_err,
    output logic        timeout,
`ifdef FIR_FEEDER_STATS_EN
    output logic [15:0] sample_count,
    output logic [7:0]  drop_count,
`endif
    output logic [2:0]  o_dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_TMO_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [1:0]    C_IDX_LAST = 2'(NUM_COEFF - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_C_ASSERT  = 3'd1;
    localparam logic [2:0] ST_C_WAITLOW = 3'd2;
    localparam logic [2:0] ST_S_ASSERT  = 3'd3;
    localparam logic [2:0] ST_S_WAITLOW = 3'd4;

    // Handshake: a strobe (load_coeff or data_ready) rises with its data already stable,
    // holds until modwait=1 is sampled, then the next strobe waits for modwait=0 to be sampled.

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_bank [4];

    logic [2:0]    r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_pending;
    logic          r_res_pend;
    logic [15:0]   r_sample_data;
    logic [15:0]   r_fir_coeff;
    logic          r_data_ready;
    logic          r_load_coeff;
    logic          r_result_valid;
    logic [15:0]   r_result_data;
    logic          r_result_err;
    logic          r_timeout;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_seq_busy;
    logic [1:0]    w_idx_next;

    assign w_full     = (r_count == C_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push_ok  = push && !w_full;
    assign w_pop      = (r_state == ST_IDLE) && !r_pending && !w_empty;
    assign w_seq_busy = (r_state == ST_C_ASSERT) || (r_state == ST_C_WAITLOW);
    assign w_idx_next = r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_bank[i] <= '0;
            end
        end else if (coeff_wr) begin
            r_bank[coeff_idx] <= coeff_wdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_tmo_cnt      <= '0;
            r_pending      <= 1'b0;
            r_res_pend     <= 1'b0;
            r_sample_data  <= '0;
            r_fir_coeff    <= '0;
            r_data_ready   <= 1'b0;
            r_load_coeff   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_result_err   <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_res_pend     <= 1'b0;
            r_result_valid <= r_res_pend;
            if (coeff_start && !w_seq_busy) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_idx        <= '0;
                        r_fir_coeff  <= r_bank[0];
                        r_load_coeff <= 1'b1;
                        r_tmo_cnt    <= '0;
                        r_state      <= ST_C_ASSERT;
                    end else if (!w_empty) begin
                        r_sample_data <= r_mem[r_rd_ptr];
                        r_data_ready  <= 1'b1;
                        r_tmo_cnt     <= '0;
                        r_state       <= ST_S_ASSERT;
                    end
                end
                ST_C_ASSERT: begin
                    if (modwait) begin
                        r_load_coeff <= 1'b0;
                        r_state      <= ST_C_WAITLOW;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_load_coeff <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_pending    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_C_WAITLOW: begin
                    if (!modwait) begin
                        if (r_idx != C_IDX_LAST) begin
                            r_idx        <= w_idx_next;
                            r_fir_coeff  <= r_bank[w_idx_next];
                            r_load_coeff <= 1'b1;
                            r_tmo_cnt    <= '0;
                            r_state      <= ST_C_ASSERT;
                        end else begin
                            r_pending <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_S_ASSERT: begin
                    if (modwait) begin
                        r_data_ready <= 1'b0;
                        r_state      <= ST_S_WAITLOW;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        // The sample is dropped here; no result is produced for it.
                        r_data_ready <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_S_WAITLOW: begin
                    if (!modwait) begin
                        r_result_data <= fir_out;
                        r_result_err  <= fir_err;
                        r_res_pend    <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_data_ready <= 1'b0;
                    r_load_coeff <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_FEEDER_STATS_EN
    logic [15:0] r_sample_count;
    logic [7:0]  r_drop_count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sample_count <= '0;
            r_drop_count   <= '0;
        end else begin
            if (r_res_pend && (r_sample_count != 16'hFFFF)) begin
                r_sample_count <= r_sample_count + 16'd1;
            end
            if (push && w_full && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign sample_count = r_sample_count;
    assign drop_count   = r_drop_count;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign fifo_full       = w_full;
    assign sample_data     = r_sample_data;
    assign fir_coefficient = r_fir_coeff;
    assign data_ready      = r_data_ready;
    assign load_coeff      = r_load_coeff;
    assign result_valid    = r_result_valid;
    assign result_data     = r_result_data;
    assign result_err      = r_result_err;
    assign timeout         = r_timeout;
    assign o_dbg_state     = r_state;

endmodule
